// File: rtl/uart_mike_pkg.sv
// Shared constants and FSM state types for the uart_mike serial block.
// Frames are start, LSB-first data, odd parity, stop.
package uart_mike_pkg;

  localparam int UART_DATA_WIDTH   = 8;
  localparam int UART_CLKS_PER_BIT = 10;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_e;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_e;

endpackage

// File: rtl/uart_mike_baud_cnt.sv
// Bit-period counter: wraps every CLKS_PER_BIT cycles and is held at zero while restart is high.
// mid_tick marks the centre of a bit and end_tick marks its last cycle.
module uart_mike_baud_cnt
  import uart_mike_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic n_rst,
  input  logic restart,
  output logic mid_tick,
  output logic end_tick
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] MID_CNT = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] END_CNT = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (restart || (cnt_q == END_CNT)) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (n_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign mid_tick = (cnt_q == MID_CNT);
  assign end_tick = (cnt_q == END_CNT);

endmodule

// File: rtl/uart_mike.sv
// Full-duplex UART with odd parity; RX and TX run independently, each with its own bit-period counter.
// Reset is synchronous and asserted while n_rst is high.
module uart_mike
  import uart_mike_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int DATA_W       = UART_DATA_WIDTH
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_send,
  input  logic              rx,
  output logic              tx,
  output logic              parity_error,
  output logic              rx_flag,
  output logic [DATA_W-1:0] rx_data,
  input  logic              rx_flag_clr
);

  localparam int IW = $clog2(DATA_W + 1);
  localparam logic [IW-1:0] LAST_BIT = IW'(DATA_W - 1);

  logic rx_meta_q, rx_sync_q;
  rx_state_e rx_state_q, rx_state_d;
  logic [IW-1:0] rx_idx_q, rx_idx_d;
  logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic rx_par_q, rx_par_d;
  logic parity_error_q, parity_error_d;
  logic rx_flag_q, rx_flag_d;
  logic rx_mid_tick, rx_end_tick;

  tx_state_e tx_state_q, tx_state_d;
  logic [IW-1:0] tx_idx_q, tx_idx_d;
  logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
  logic tx_par_q, tx_par_d;
  logic tx_q, tx_d;
  logic tx_mid_tick, tx_end_tick;

  logic unused_ticks;
  assign unused_ticks = rx_end_tick ^ tx_mid_tick;

  uart_mike_baud_cnt #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx_baud (
    .clk     (clk),
    .n_rst   (n_rst),
    .restart (rx_state_q == RX_IDLE),
    .mid_tick(rx_mid_tick),
    .end_tick(rx_end_tick)
  );

  uart_mike_baud_cnt #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx_baud (
    .clk     (clk),
    .n_rst   (n_rst),
    .restart (tx_state_q == TX_IDLE),
    .mid_tick(tx_mid_tick),
    .end_tick(tx_end_tick)
  );

  // Receiver samples each bit once at its centre; a set on the stop sample beats a clear.
  always_comb begin
    rx_state_d     = rx_state_q;
    rx_idx_d       = rx_idx_q;
    rx_shift_d     = rx_shift_q;
    rx_par_d       = rx_par_q;
    rx_data_d      = rx_data_q;
    parity_error_d = parity_error_q;
    rx_flag_d      = rx_flag_clr ? 1'b0 : rx_flag_q;
    case (rx_state_q)
      RX_IDLE: begin
        if (!rx_sync_q) rx_state_d = RX_START;
      end
      RX_START: begin
        if (rx_mid_tick) begin
          rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
          rx_idx_d   = '0;
        end
      end
      RX_DATA: begin
        if (rx_mid_tick) begin
          rx_shift_d = {rx_sync_q, rx_shift_q[DATA_W-1:1]};
          if (rx_idx_q == LAST_BIT) rx_state_d = RX_PARITY;
          else rx_idx_d = rx_idx_q + IW'(1);
        end
      end
      RX_PARITY: begin
        if (rx_mid_tick) begin
          rx_par_d   = rx_sync_q;
          rx_state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (rx_mid_tick) begin
          rx_data_d      = rx_shift_q;
          parity_error_d = ~(^{rx_par_q, rx_shift_q});
          rx_flag_d      = 1'b1;
          rx_state_d     = RX_IDLE;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_idx_d   = tx_idx_q;
    tx_shift_d = tx_shift_q;
    tx_par_d   = tx_par_q;
    tx_d       = tx_q;
    case (tx_state_q)
      TX_IDLE: begin
        if (tx_send) begin
          tx_shift_d = tx_data;
          tx_par_d   = ~(^tx_data);
          tx_d       = 1'b0;
          tx_state_d = TX_START;
        end
      end
      TX_START: begin
        if (tx_end_tick) begin
          tx_d       = tx_shift_q[0];
          tx_shift_d = {1'b0, tx_shift_q[DATA_W-1:1]};
          tx_idx_d   = '0;
          tx_state_d = TX_DATA;
        end
      end
      TX_DATA: begin
        if (tx_end_tick) begin
          if (tx_idx_q == LAST_BIT) begin
            tx_d       = tx_par_q;
            tx_state_d = TX_PARITY;
          end else begin
            tx_d       = tx_shift_q[0];
            tx_shift_d = {1'b0, tx_shift_q[DATA_W-1:1]};
            tx_idx_d   = tx_idx_q + IW'(1);
          end
        end
      end
      TX_PARITY: begin
        if (tx_end_tick) begin
          tx_d       = 1'b1;
          tx_state_d = TX_STOP;
        end
      end
      TX_STOP: begin
        if (tx_end_tick) tx_state_d = TX_IDLE;
      end
      default: begin
        tx_d       = 1'b1;
        tx_state_d = TX_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (n_rst) begin
      rx_meta_q      <= 1'b1;
      rx_sync_q      <= 1'b1;
      rx_state_q     <= RX_IDLE;
      rx_idx_q       <= '0;
      rx_shift_q     <= '0;
      rx_par_q       <= 1'b0;
      rx_data_q      <= '0;
      parity_error_q <= 1'b0;
      rx_flag_q      <= 1'b0;
      tx_state_q     <= TX_IDLE;
      tx_idx_q       <= '0;
      tx_shift_q     <= '0;
      tx_par_q       <= 1'b0;
      tx_q           <= 1'b1;
    end else begin
      rx_meta_q      <= rx;
      rx_sync_q      <= rx_meta_q;
      rx_state_q     <= rx_state_d;
      rx_idx_q       <= rx_idx_d;
      rx_shift_q     <= rx_shift_d;
      rx_par_q       <= rx_par_d;
      rx_data_q      <= rx_data_d;
      parity_error_q <= parity_error_d;
      rx_flag_q      <= rx_flag_d;
      tx_state_q     <= tx_state_d;
      tx_idx_q       <= tx_idx_d;
      tx_shift_q     <= tx_shift_d;
      tx_par_q       <= tx_par_d;
      tx_q           <= tx_d;
    end
  end

  assign tx           = tx_q;
  assign rx_data      = rx_data_q;
  assign parity_error = parity_error_q;
  assign rx_flag      = rx_flag_q;

endmodule

// File: tb/tb_uart_mike.sv
// Directed and randomized bench for uart_mike; expected line waveforms and received
// values come from a frame-level model (start, data LSB first, odd parity, stop).
module tb_uart_mike;

  localparam int N          = 10;
  localparam int W          = 8;
  localparam int FRAME_BITS = W + 3;

  logic         clk         = 1'b0;
  logic         n_rst       = 1'b1;
  logic [W-1:0] tx_data     = '0;
  logic         tx_send     = 1'b0;
  logic         rx          = 1'b1;
  logic         rx_flag_clr = 1'b0;
  logic         tx;
  logic         parity_error;
  logic         rx_flag;
  logic [W-1:0] rx_data;

  int n_checks = 0;
  int n_fail   = 0;

  uart_mike #(.CLKS_PER_BIT(N), .DATA_W(W)) dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .tx_data     (tx_data),
    .tx_send     (tx_send),
    .rx          (rx),
    .tx          (tx),
    .parity_error(parity_error),
    .rx_flag     (rx_flag),
    .rx_data     (rx_data),
    .rx_flag_clr (rx_flag_clr)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic logic odd_parity(input logic [W-1:0] d);
    return (($countones(d) % 2) == 0) ? 1'b1 : 1'b0;
  endfunction

  function automatic logic [FRAME_BITS-1:0] make_frame(input logic [W-1:0] d, input logic par);
    return {1'b1, par, d, 1'b0};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive the first count bits of a frame onto rx, one bit period each.
  task automatic drive_rx_bits(input logic [FRAME_BITS-1:0] bits, input int count);
    for (int i = 0; i < count; i++) begin
      rx = bits[i];
      repeat (N) @(negedge clk);
    end
  endtask

  // Request a frame with a 2-cycle tx_send, optionally re-pulse it mid-frame, and
  // compare every cycle of the line against the modelled frame, then the idle line.
  task automatic run_tx(input logic [W-1:0] d, input int repulse_at, input string tag);
    logic [FRAME_BITS-1:0] exp_bits;
    int bad;
    int k;
    exp_bits = make_frame(d, odd_parity(d));
    tx_data  = d;
    tx_send  = 1'b1;
    for (int b = 0; b < FRAME_BITS; b++) begin
      bad = 0;
      for (int c = 0; c < N; c++) begin
        @(negedge clk);
        if (tx !== exp_bits[b]) bad++;
        k = b * N + c;
        if (k == 0) tx_data = ~d;
        if (k == 1) tx_send = 1'b0;
        if (k == repulse_at) tx_send = 1'b1;
        if (k == repulse_at + 1) tx_send = 1'b0;
      end
      check($sformatf("%s bit%0d wrong cycles", tag, b), 32'(bad), 32'd0);
    end
    bad = 0;
    for (int c = 0; c < 2 * N; c++) begin
      @(negedge clk);
      if (tx !== 1'b1) bad++;
    end
    check({tag, " idle wrong cycles"}, 32'(bad), 32'd0);
  endtask

  task automatic pulse_clear(input string tag);
    rx_flag_clr = 1'b1;
    check({tag, " flag before clear edge"}, 32'(rx_flag), 32'd1);
    @(negedge clk);
    rx_flag_clr = 1'b0;
    check({tag, " flag after clear"}, 32'(rx_flag), 32'd0);
  endtask

  initial begin
    logic [W-1:0] d;
    logic [W-1:0] dt;
    logic         p;
    logic         exp_perr;
    int           rep;

    repeat (3) @(negedge clk);
    n_rst = 1'b0;
    repeat (2) @(negedge clk);
    check("reset tx", 32'(tx), 32'd1);
    check("reset rx_flag", 32'(rx_flag), 32'd0);
    check("reset rx_data", 32'(rx_data), 32'd0);
    check("reset parity_error", 32'(parity_error), 32'd0);

    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (3 * N) @(negedge clk);
    check("false start rx_flag", 32'(rx_flag), 32'd0);
    check("false start rx_data", 32'(rx_data), 32'd0);

    drive_rx_bits(make_frame(8'h55, 1'b1), FRAME_BITS);
    repeat (2) @(negedge clk);
    check("rx55 good data", 32'(rx_data), 32'h55);
    check("rx55 good flag", 32'(rx_flag), 32'd1);
    check("rx55 good parity_error", 32'(parity_error), 32'd0);
    pulse_clear("rx55 good");

    drive_rx_bits(make_frame(8'h55, 1'b0), FRAME_BITS);
    repeat (2) @(negedge clk);
    check("rx55 bad data", 32'(rx_data), 32'h55);
    check("rx55 bad flag", 32'(rx_flag), 32'd1);
    check("rx55 bad parity_error", 32'(parity_error), 32'd1);

    d = W'($urandom);
    drive_rx_bits(make_frame(d, odd_parity(d)), FRAME_BITS);
    repeat (2) @(negedge clk);
    check("overwrite data", 32'(rx_data), 32'(d));
    check("overwrite parity_error", 32'(parity_error), 32'd0);
    check("overwrite flag", 32'(rx_flag), 32'd1);
    pulse_clear("overwrite");

    run_tx(8'h55, -10, "tx55");

    for (int i = 0; i < 4; i++) begin
      d        = W'($urandom);
      dt       = W'($urandom);
      p        = ($urandom_range(0, 1) == 1) ? odd_parity(d) : ~odd_parity(d);
      exp_perr = (p != odd_parity(d));
      rep      = $urandom_range(3 * N, 8 * N);
      fork
        drive_rx_bits(make_frame(d, p), FRAME_BITS);
        run_tx(dt, rep, $sformatf("dual%0d tx", i));
      join
      check($sformatf("dual%0d rx_data", i), 32'(rx_data), 32'(d));
      check($sformatf("dual%0d parity_error", i), 32'(parity_error), 32'(exp_perr));
      check($sformatf("dual%0d rx_flag", i), 32'(rx_flag), 32'd1);
      pulse_clear($sformatf("dual%0d", i));
    end

    tx_data = 8'h00;
    tx_send = 1'b1;
    rx      = 1'b0;
    @(negedge clk);
    tx_send = 1'b0;
    repeat (5 * N - 1) @(negedge clk);
    check("midframe tx busy low", 32'(tx), 32'd0);
    n_rst = 1'b1;
    @(negedge clk);
    check("midframe reset tx", 32'(tx), 32'd1);
    check("midframe reset rx_data", 32'(rx_data), 32'd0);
    check("midframe reset rx_flag", 32'(rx_flag), 32'd0);
    check("midframe reset parity_error", 32'(parity_error), 32'd0);
    rx = 1'b1;
    @(negedge clk);
    n_rst = 1'b0;
    repeat (3 * N) @(negedge clk);
    check("after abort rx_flag", 32'(rx_flag), 32'd0);
    check("after abort rx_data", 32'(rx_data), 32'd0);
    check("after abort tx", 32'(tx), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
